// File: rtl/mux_scan_pkg.sv
// Shared constants and helpers for the channel scan multiplexer and its slot counter.
package mux_scan_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_AUTO   = 1'b1;

    // Bits needed to hold values 0..v-1.
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_scan_nbit_counter.sv
// Modulo-M counter with clear and increment; max_tick flags the terminal count.
module mod_counter
    import mux_scan_pkg::*;
#(
    parameter  int M = 4,
    localparam int W = clog2(M)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         max_tick
);

    assign max_tick = (count == W'(M - 1));

    // Clear wins over increment so a manual load always restarts the slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= max_tick ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/mux_scan_nbit.sv
// N-bit channel multiplexer with manual select or timed auto scan and one-hot
// channel drive with optional blanking at the start of each slot.
module mux_scan_nbit
    import mux_scan_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int CH    = 8,
    parameter  int DIV   = 50000,
    parameter  int BLANK = 0,
    localparam int SW    = clog2(CH)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            en,
    input  logic            mode,
    input  logic [SW-1:0]   s,
    input  logic [CH*N-1:0] w,
    output logic [N-1:0]    f,
    output logic [SW-1:0]   sel,
    output logic [CH-1:0]   ch_en,
    output logic            tick,
    output logic            err
);

    localparam int CW = clog2(DIV);

    logic          ready;
    logic          run;
    logic          auto_run;
    logic          man_run;
    logic [CW-1:0] count;
    logic [CW-1:0] cnt_nxt;
    logic          max_tick;
    logic          s_valid;
    logic [SW-1:0] sel_inc;

    logic [N-1:0]  f_nxt;
    logic [SW-1:0] sel_nxt;
    logic [CH-1:0] ch_en_nxt;
    logic          tick_nxt;
    logic          err_nxt;

    // One arming cycle after reset release keeps the first state change off
    // the edge that immediately follows deassertion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready <= 1'b0;
        end else begin
            ready <= 1'b1;
        end
    end

    assign run      = ready & en;
    assign auto_run = run & (mode == MODE_AUTO);
    assign man_run  = run & (mode == MODE_MANUAL);

    mod_counter #(.M(DIV)) u_slot (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (man_run),
        .inc      (auto_run),
        .count    (count),
        .max_tick (max_tick)
    );

    always_comb begin
        cnt_nxt = count;
        if (man_run) begin
            cnt_nxt = '0;
        end else if (auto_run) begin
            cnt_nxt = max_tick ? '0 : count + 1'b1;
        end
    end

    assign s_valid = (int'(s) < CH);
    assign sel_inc = (sel == SW'(CH - 1)) ? '0 : sel + 1'b1;

    always_comb begin
        f_nxt     = f;
        sel_nxt   = sel;
        ch_en_nxt = ch_en;
        tick_nxt  = 1'b0;
        err_nxt   = err;
        if (ready && !en) begin
            ch_en_nxt = '0;
        end else if (run) begin
            if (mode == MODE_AUTO) begin
                err_nxt  = 1'b0;
                tick_nxt = max_tick;
                if (max_tick) begin
                    sel_nxt = sel_inc;
                end
            end else if (s_valid) begin
                sel_nxt = s;
                err_nxt = 1'b0;
            end else begin
                err_nxt = 1'b1;
            end
            // Data follows the channel being selected on this edge.
            f_nxt = w[sel_nxt*N +: N];
            if (err_nxt || (auto_run && (int'(cnt_nxt) < BLANK))) begin
                ch_en_nxt = '0;
            end else begin
                ch_en_nxt = CH'(1) << sel_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            f     <= '0;
            sel   <= '0;
            ch_en <= '0;
            tick  <= 1'b0;
            err   <= 1'b0;
        end else begin
            f     <= f_nxt;
            sel   <= sel_nxt;
            ch_en <= ch_en_nxt;
            tick  <= tick_nxt;
            err   <= err_nxt;
        end
    end

endmodule

// File: tb/tb_mux_scan_nbit.sv
// Bench for mux_scan_nbit: directed vector table, reset/data corner sequences,
// then randomized stimulus against a rule-level reference model.
module tb_mux_scan_nbit;

    localparam int N     = 4;
    localparam int CH    = 5;
    localparam int DIV   = 4;
    localparam int BLANK = 1;
    localparam int SW    = 3;

    logic            clk;
    logic            reset_n;
    logic            en;
    logic            mode;
    logic [SW-1:0]   s;
    logic [CH*N-1:0] w;
    logic [N-1:0]    f;
    logic [SW-1:0]   sel;
    logic [CH-1:0]   ch_en;
    logic            tick;
    logic            err;

    int total_cnt = 0;
    int pass_cnt  = 0;

    mux_scan_nbit #(.N(N), .CH(CH), .DIV(DIV), .BLANK(BLANK)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .mode    (mode),
        .s       (s),
        .w       (w),
        .f       (f),
        .sel     (sel),
        .ch_en   (ch_en),
        .tick    (tick),
        .err     (err)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: slot position, channel index, flags as plain integers
    int m_ready = 0;
    int m_cnt   = 0;
    int m_sel   = 0;
    int m_f     = 0;
    int m_chen  = 0;
    int m_tick  = 0;
    int m_err   = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_ready = 0; m_cnt = 0; m_sel = 0; m_f = 0;
            m_chen = 0; m_tick = 0; m_err = 0;
        end else if (m_ready == 0) begin
            m_ready = 1;
        end else if (!en) begin
            m_tick = 0;
            m_chen = 0;
        end else begin
            if (mode) begin
                m_err  = 0;
                m_tick = (m_cnt == DIV - 1) ? 1 : 0;
                if (m_tick == 1) m_sel = (m_sel + 1) % CH;
                m_cnt = (m_cnt + 1) % DIV;
            end else begin
                m_tick = 0;
                m_cnt  = 0;
                if (int'(s) < CH) begin
                    m_sel = int'(s);
                    m_err = 0;
                end else begin
                    m_err = 1;
                end
            end
            m_f = int'((w >> (m_sel * N)) & 20'hF);
            if (m_err == 1 || (mode && m_cnt < BLANK)) m_chen = 0;
            else m_chen = 1 << m_sel;
        end
    end

    task automatic chk(input string name, input logic [3:0] ef, input logic [2:0] es,
                       input logic [4:0] ec, input logic et, input logic ee);
        total_cnt++;
        if ({f, sel, ch_en, tick, err} === {ef, es, ec, et, ee}) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s @%0t: got f=%h sel=%0d ch_en=%b tick=%b err=%b, expected f=%h sel=%0d ch_en=%b tick=%b err=%b",
                     name, $time, f, sel, ch_en, tick, err, ef, es, ec, et, ee);
        end
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic       en;
        logic       mode;
        logic [2:0] s;
        int         reps;
        logic [3:0] f;
        logic [2:0] sel;
        logic [4:0] chen;
        logic       tick;
        logic       err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic ven, input logic vmode, input logic [2:0] vs,
                                input int vreps, input logic [2:0] vsel, input logic [3:0] vf,
                                input logic [4:0] vchen, input logic vtick, input logic verr);
        vec_t v;
        v.en = ven; v.mode = vmode; v.s = vs; v.reps = vreps;
        v.sel = vsel; v.f = vf; v.chen = vchen; v.tick = vtick; v.err = verr;
        return v;
    endfunction

    initial begin
        // auto scan from reset: arming edge, then slots of DIV cycles
        tbl.push_back(mk(1, 1, 0, 1, 0, 4'h0, 5'b00000, 0, 0));
        tbl.push_back(mk(1, 1, 0, 3, 0, 4'h1, 5'b00001, 0, 0));
        tbl.push_back(mk(1, 1, 0, 1, 1, 4'h2, 5'b00000, 1, 0));
        tbl.push_back(mk(1, 1, 0, 3, 1, 4'h2, 5'b00010, 0, 0));
        tbl.push_back(mk(1, 1, 0, 1, 2, 4'h3, 5'b00000, 1, 0));
        tbl.push_back(mk(1, 1, 0, 3, 2, 4'h3, 5'b00100, 0, 0));
        tbl.push_back(mk(1, 1, 0, 1, 3, 4'h4, 5'b00000, 1, 0));
        tbl.push_back(mk(1, 1, 0, 3, 3, 4'h4, 5'b01000, 0, 0));
        tbl.push_back(mk(1, 1, 0, 1, 4, 4'h5, 5'b00000, 1, 0));
        tbl.push_back(mk(1, 1, 0, 3, 4, 4'h5, 5'b10000, 0, 0));
        tbl.push_back(mk(1, 1, 0, 1, 0, 4'h1, 5'b00000, 1, 0));
        tbl.push_back(mk(1, 1, 0, 1, 0, 4'h1, 5'b00001, 0, 0));
        // manual select, invalid select, back to valid
        tbl.push_back(mk(1, 0, 3, 1, 3, 4'h4, 5'b01000, 0, 0));
        tbl.push_back(mk(1, 0, 6, 2, 3, 4'h4, 5'b00000, 0, 1));
        tbl.push_back(mk(1, 0, 1, 1, 1, 4'h2, 5'b00010, 0, 0));
        // manual to auto: full slot from current channel
        tbl.push_back(mk(1, 1, 0, 3, 1, 4'h2, 5'b00010, 0, 0));
        tbl.push_back(mk(1, 1, 0, 1, 2, 4'h3, 5'b00000, 1, 0));
        tbl.push_back(mk(1, 1, 0, 3, 2, 4'h3, 5'b00100, 0, 0));
        // wrap coinciding with switch to manual: manual load wins, no tick
        tbl.push_back(mk(1, 0, 4, 1, 4, 4'h5, 5'b10000, 0, 0));
        tbl.push_back(mk(1, 0, 7, 1, 4, 4'h5, 5'b00000, 0, 1));
        tbl.push_back(mk(1, 1, 0, 1, 4, 4'h5, 5'b10000, 0, 0));
        // freeze mid-slot, then finish the remaining count
        tbl.push_back(mk(0, 1, 0, 10, 4, 4'h5, 5'b00000, 0, 0));
        tbl.push_back(mk(1, 1, 0, 2, 4, 4'h5, 5'b10000, 0, 0));
        tbl.push_back(mk(1, 1, 0, 1, 0, 4'h1, 5'b00000, 1, 0));
    end

    initial begin
        int found;
        reset_n = 1'b0;
        en      = 1'b0;
        mode    = 1'b0;
        s       = '0;
        w       = {4'h5, 4'h4, 4'h3, 4'h2, 4'h1};
        repeat (3) @(negedge clk);
        chk("reset_state", 4'h0, 0, 5'b00000, 0, 0);

        reset_n = 1'b1;
        foreach (tbl[i]) begin
            en   = tbl[i].en;
            mode = tbl[i].mode;
            s    = tbl[i].s;
            for (int r = 0; r < tbl[i].reps; r++) begin
                step();
                chk($sformatf("vec%0d_rep%0d", i, r), tbl[i].f, tbl[i].sel, tbl[i].chen,
                    tbl[i].tick, tbl[i].err);
            end
        end

        // live data change on the displayed channel reaches f one cycle later
        en = 1'b1; mode = 1'b1;
        repeat (3) step();
        step();
        chk("to_ch1", 4'h2, 1, 5'b00000, 1, 0);
        w[7:4] = 4'hA;
        step();
        chk("w_change", 4'hA, 1, 5'b00010, 0, 0);

        // asynchronous reset in the middle of the channel-3 slot
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            step();
            if (sel == 3) found = 1;
        end
        if (found == 0) begin
            total_cnt++;
            $display("FAIL wait_sel3: sel never reached 3, last sel=%0d", sel);
        end
        step();
        #2 reset_n = 1'b0;
        #1 chk("async_reset", 4'h0, 0, 5'b00000, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        chk("rst_arm", 4'h0, 0, 5'b00000, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("rst_hold%0d", i), 4'h1, 0, 5'b00001, 0, 0);
        end
        step();
        chk("rst_first_adv", 4'hA, 1, 5'b00000, 1, 0);

        // randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) mode = ~mode;
            s = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) w = 20'($urandom);
            step();
            chk($sformatf("rand%0d", i), 4'(m_f), 3'(m_sel), 5'(m_chen), m_tick[0], m_err[0]);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
